vga_mem_arbiter: RTL

//  Upstream feeder of the VGA subsystem: supplies rdataForVga for the 8-bit word index the video generator drives.

---
 rtl/vga_mem_pkg.sv | 24 ++
 rtl/vga_mem_arbiter_if.sv | 37 +++
 rtl/vga_starve_counter.sv | 40 ++++
 rtl/vga_mem_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_mem_pkg : shared types and defaults for the VGA/CPU memory arbiter      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package vga_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RESP = 2'd2
    } vga_arb_state_t;

    localparam logic [31:0] VGA_BASE_DEF   = 32'h0000_0400;
    localparam int          MAX_STARVE_DEF = 4;

    // Byte address of a VGA word index; the add wraps modulo 2^32.
    function automatic logic [31:0] vga_word_addr(input logic [31:0] base,
                                                  input logic [29:0] idx);
        return base + {idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_mem_arbiter_if : video, CPU and memory-port signals of the arbiter     |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
interface vga_mem_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int VADDR_W = 8
);
    logic [VADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0]  vga_rdata;
    logic               vga_valid;
    logic               cpu_re;
    logic               cpu_we;
    logic [31:0]        cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic               cpu_stall;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               cpu_rvalid;
    logic [31:0]        mem_addr;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;

    modport slave (
        input  vga_addr, cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vga_rdata, vga_valid, cpu_stall, cpu_rdata, cpu_rvalid,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vga_addr, cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vga_rdata, vga_valid, cpu_stall, cpu_rdata, cpu_rvalid,
               mem_addr, mem_we, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/vga_starve_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_starve_counter : saturating count of CPU grants while VGA is pending   |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module vga_starve_counter #(
    parameter int MAX_STARVE = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic inc,
    input  wire logic clr,
    output logic      at_max
);
    localparam int CW = $clog2(MAX_STARVE + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_STARVE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == C_MAX);
endmodule
`default_nettype wire

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_mem_arbiter : shares one sync-read memory port between CPU and VGA,    |
// |                   holding a coherent copy of the current video word        |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          VADDR_W    = 8,
    parameter logic [31:0] VGA_BASE   = VGA_BASE_DEF,
    parameter int          MAX_STARVE = MAX_STARVE_DEF
) (
    input  wire logic        clk,
    input  wire logic        rstBtn,
    vga_mem_arbiter_if.slave bus
);
    vga_arb_state_t     state_q, state_d;
    logic [VADDR_W-1:0] tag_q, tag_d;
    logic               tag_valid_q, tag_valid_d;
    logic [VADDR_W-1:0] issued_q, issued_d;
    logic [DATA_W-1:0]  vga_rdata_q, vga_rdata_d;
    logic               cpu_rvalid_q, cpu_rvalid_d;

    logic        w_active;
    logic        w_cpu_req;
    logic        w_vga_grant;
    logic        w_cpu_grant;
    logic        w_cpu_wr;
    logic        w_cpu_rd;
    logic        w_tag_hit;
    logic        w_at_max;
    logic [31:0] w_vga_mem_addr;
    logic [31:0] w_tag_addr;
    logic [31:0] w_inflight_addr;

    // Combinational outputs are forced to their idle values while reset is held.
    assign w_active        = ~rstBtn;
    assign w_cpu_req       = bus.cpu_re | bus.cpu_we;
    assign w_vga_grant     = (state_q == PEND) && (!w_cpu_req || w_at_max);
    assign w_cpu_grant     = w_cpu_req && !w_vga_grant;
    assign w_cpu_wr        = w_cpu_grant && bus.cpu_we;
    assign w_cpu_rd        = w_cpu_grant && bus.cpu_re && !bus.cpu_we;
    assign w_tag_hit       = tag_valid_q && (tag_q == bus.vga_addr);
    assign w_vga_mem_addr  = vga_word_addr(VGA_BASE, 30'(bus.vga_addr));
    assign w_tag_addr      = vga_word_addr(VGA_BASE, 30'(tag_q));
    assign w_inflight_addr = vga_word_addr(VGA_BASE, 30'(issued_q));

    vga_starve_counter #(.MAX_STARVE(MAX_STARVE)) u_starve (
        .clk    (clk),
        .rst    (rstBtn),
        .inc    ((state_q == PEND) && w_cpu_grant),
        .clr    (state_q == RESP),
        .at_max (w_at_max)
    );

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        tag_valid_d  = tag_valid_q;
        issued_d     = issued_q;
        vga_rdata_d  = vga_rdata_q;
        cpu_rvalid_d = w_cpu_rd;
        case (state_q)
            IDLE: begin
                if (!w_tag_hit) state_d = PEND;
            end
            PEND: begin
                if (w_vga_grant) begin
                    issued_d = bus.vga_addr;
                    state_d  = RESP;
                end
            end
            RESP: begin
                tag_d       = issued_q;
                tag_valid_d = 1'b1;
                // A CPU write landing on the in-flight word beats the stale read data.
                if (w_cpu_wr && (bus.cpu_addr == w_inflight_addr)) begin
                    vga_rdata_d = bus.cpu_wdata;
                end else begin
                    vga_rdata_d = bus.mem_rdata;
                end
                state_d = (issued_q == bus.vga_addr) ? IDLE : PEND;
            end
            default: state_d = PEND;
        endcase
        if ((state_q != RESP) && w_cpu_wr && tag_valid_q && (bus.cpu_addr == w_tag_addr)) begin
            vga_rdata_d = bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rstBtn) begin
        if (rstBtn) begin
            state_q      <= PEND;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            issued_q     <= '0;
            vga_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            tag_valid_q  <= tag_valid_d;
            issued_q     <= issued_d;
            vga_rdata_q  <= vga_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    assign bus.vga_rdata  = vga_rdata_q;
    assign bus.vga_valid  = w_tag_hit;
    assign bus.cpu_stall  = w_active && w_cpu_req && w_vga_grant;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : '0;
    assign bus.mem_we     = w_active && w_cpu_wr;
    assign bus.mem_wdata  = (w_active && w_cpu_wr) ? bus.cpu_wdata : '0;
    assign bus.mem_addr   = !w_active   ? 32'h0 :
                            w_vga_grant ? w_vga_mem_addr :
                            w_cpu_grant ? bus.cpu_addr : 32'h0;
endmodule
`default_nettype wire
